// File: rtl/sobel_vga_top.sv
// Checkerboard source, 3x3 Sobel edge magnitude over two line buffers, VGA 640x480 raster out.
// The generator runs one line plus two pixels ahead of the displayed raster.
module sobel_vga_top #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_TOT    = 800,
  parameter int unsigned HS_BEG   = 656,
  parameter int unsigned HS_END   = 751,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_TOT    = 521,
  parameter int unsigned VS_BEG   = 490,
  parameter int unsigned VS_END   = 491,
  parameter int unsigned SQ_SHIFT = 6
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out_data,
  output logic [5:0] xrgb,
  output logic       xhs,
  output logic       xvs
);

  localparam int unsigned CW = 10;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t HLast    = cnt_t'(H_TOT - 1);
  localparam cnt_t VLast    = cnt_t'(V_TOT - 1);
  localparam cnt_t HVis     = cnt_t'(H_VIS);
  localparam cnt_t VVis     = cnt_t'(V_VIS);
  localparam cnt_t HVisLast = cnt_t'(H_VIS - 1);
  localparam cnt_t VVisLast = cnt_t'(V_VIS - 1);
  localparam cnt_t HsBeg    = cnt_t'(HS_BEG);
  localparam cnt_t HsEnd    = cnt_t'(HS_END);
  localparam cnt_t VsBeg    = cnt_t'(VS_BEG);
  localparam cnt_t VsEnd    = cnt_t'(VS_END);
  // Generator sits 802 pixels ahead: bottom row of the window is one line below the display.
  localparam cnt_t GenH0    = cnt_t'(2);
  localparam cnt_t GenV0    = cnt_t'(1);
  localparam cnt_t RowOne   = cnt_t'(1);

  cnt_t h_q, h_d, v_q, v_d;
  cnt_t gh_q, gh_d, gv_q, gv_d;

  logic [7:0] out_data_q, out_data_d;
  logic [5:0] xrgb_q, xrgb_d;
  logic       xhs_q, xhs_d, xvs_q, xvs_d;

  logic [7:0] lb_top_q [H_VIS];
  logic [7:0] lb_mid_q [H_VIS];
  logic [7:0] w_q [3][3];
  logic [7:0] w_d [3][3];

  logic       gen_vis, gen_prime;
  cnt_t       rd_addr, prime_addr;
  logic [7:0] pix_bot;

  logic [9:0]        gx_p, gx_n, gy_p, gy_n;
  logic signed [11:0] gx, gy;
  logic [11:0]       ax, ay, mag_sum;
  logic [7:0]        mag, pix_m;
  logic              disp_vis, disp_edge;

  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  always_comb begin
    h_d  = h_q + 1'b1;
    v_d  = v_q;
    gh_d = gh_q + 1'b1;
    gv_d = gv_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
    if (gh_q == HLast) begin
      gh_d = '0;
      gv_d = (gv_q == VLast) ? '0 : gv_q + 1'b1;
    end
  end

  always_comb begin
    gen_vis    = gh_q < HVis;
    // Row 0 is never produced after a reset, so row 1 rebuilds it (and its own first
    // columns) from the pattern during that line's blanking.
    gen_prime  = (gv_q == RowOne) && !gen_vis;
    prime_addr = gh_q - HVis;
    rd_addr    = gen_vis ? gh_q : '0;
    pix_bot    = {8{gh_q[SQ_SHIFT] ^ gv_q[SQ_SHIFT]}};
  end

  always_ff @(posedge clk) begin
    if (gen_vis) begin
      lb_top_q[rd_addr] <= (gv_q == RowOne) ? {8{gh_q[SQ_SHIFT]}} : lb_mid_q[rd_addr];
      lb_mid_q[rd_addr] <= pix_bot;
    end else if (gen_prime) begin
      lb_top_q[prime_addr] <= {8{prime_addr[SQ_SHIFT]}};
      lb_mid_q[prime_addr] <= {8{prime_addr[SQ_SHIFT] ^ gv_q[SQ_SHIFT]}};
    end
  end

  // Window columns: [0] = x-1, [1] = x, [2] = x+1; rows: [0] = y-1, [1] = y, [2] = y+1.
  always_comb begin
    w_d       = w_q;
    w_d[0]    = w_q[1];
    w_d[1]    = w_q[2];
    w_d[2][0] = lb_top_q[rd_addr];
    w_d[2][1] = lb_mid_q[rd_addr];
    w_d[2][2] = pix_bot;
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  always_comb begin
    gx_p    = wsum(w_q[2][0], w_q[2][1], w_q[2][2]);
    gx_n    = wsum(w_q[0][0], w_q[0][1], w_q[0][2]);
    gy_p    = wsum(w_q[0][2], w_q[1][2], w_q[2][2]);
    gy_n    = wsum(w_q[0][0], w_q[1][0], w_q[2][0]);
    gx      = $signed({2'b00, gx_p}) - $signed({2'b00, gx_n});
    gy      = $signed({2'b00, gy_p}) - $signed({2'b00, gy_n});
    ax      = gx[11] ? $unsigned(-gx) : $unsigned(gx);
    ay      = gy[11] ? $unsigned(-gy) : $unsigned(gy);
    mag_sum = ax + ay;
    mag     = (mag_sum > 12'd255) ? 8'hff : mag_sum[7:0];
  end

  always_comb begin
    disp_vis   = (h_q < HVis) && (v_q < VVis);
    disp_edge  = (h_q == '0) || (h_q == HVisLast) || (v_q == '0) || (v_q == VVisLast);
    pix_m      = (disp_vis && !disp_edge) ? mag : 8'h00;
    out_data_d = pix_m;
    xrgb_d     = {3{pix_m[7:6]}};
    xhs_d      = !((h_q >= HsBeg) && (h_q <= HsEnd));
    xvs_d      = !((v_q >= VsBeg) && (v_q <= VsEnd));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      gh_q       <= GenH0;
      gv_q       <= GenV0;
      out_data_q <= 8'h00;
      xrgb_q     <= 6'h00;
      xhs_q      <= 1'b1;
      xvs_q      <= 1'b1;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      gh_q       <= gh_d;
      gv_q       <= gv_d;
      out_data_q <= out_data_d;
      xrgb_q     <= xrgb_d;
      xhs_q      <= xhs_d;
      xvs_q      <= xvs_d;
    end
  end

  assign out_data = out_data_q;
  assign xrgb     = xrgb_q;
  assign xhs      = xhs_q;
  assign xvs      = xvs_q;

endmodule

// File: tb/tb_sobel_vga_top.sv
// Bench for sobel_vga_top: full-size instance over the first lines, shrunk instance over
// many frames with random reset pulses, both against an arithmetic Sobel reference.
module tb_sobel_vga_top;

  localparam int BH_VIS = 640, BH_TOT = 800, BHS_BEG = 656, BHS_END = 751;
  localparam int BV_VIS = 480, BV_TOT = 521, BVS_BEG = 490, BVS_END = 491, BSQ = 6;
  localparam int SH_VIS = 40, SH_TOT = 50, SHS_BEG = 42, SHS_END = 45;
  localparam int SV_VIS = 30, SV_TOT = 35, SVS_BEG = 31, SVS_END = 32, SSQ = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] big_data, sm_data;
  logic [5:0] big_rgb, sm_rgb;
  logic       big_hs, big_vs, sm_hs, sm_vs;

  int n_big = 0;
  int n_sm = 0;
  int n_asserts = 0;
  int n_fails = 0;

  int         dir_n [10] = '{0, 8010, 8062, 8063, 8064, 8065, 50410, 51210, 51264, 52010};
  logic [7:0] dir_d [10] = '{8'h00, 8'h00, 8'h00, 8'hff, 8'hff, 8'h00, 8'hff, 8'hff, 8'hff,
                             8'h00};
  int         hs_n  [4]  = '{655, 656, 751, 752};
  logic       hs_e  [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #20 clk = ~clk;

  sobel_vga_top u_big (
    .clk      (clk),
    .rst      (rst),
    .out_data (big_data),
    .xrgb     (big_rgb),
    .xhs      (big_hs),
    .xvs      (big_vs)
  );

  sobel_vga_top #(
    .H_VIS    (SH_VIS),
    .H_TOT    (SH_TOT),
    .HS_BEG   (SHS_BEG),
    .HS_END   (SHS_END),
    .V_VIS    (SV_VIS),
    .V_TOT    (SV_TOT),
    .VS_BEG   (SVS_BEG),
    .VS_END   (SVS_END),
    .SQ_SHIFT (SSQ)
  ) u_small (
    .clk      (clk),
    .rst      (rst),
    .out_data (sm_data),
    .xrgb     (sm_rgb),
    .xhs      (sm_hs),
    .xvs      (sm_vs)
  );

  function automatic int pix(input int x, input int y, input int sq);
    return ((((x >> sq) ^ (y >> sq)) & 1) == 1) ? 255 : 0;
  endfunction

  function automatic logic [7:0] ref_mag(input int x, input int y, input int hv, input int vv,
                                         input int sq);
    int gx, gy, s;
    if (x <= 0 || x >= hv - 1 || y <= 0 || y >= vv - 1) return 8'h00;
    gx = (pix(x+1, y-1, sq) + 2*pix(x+1, y, sq) + pix(x+1, y+1, sq))
       - (pix(x-1, y-1, sq) + 2*pix(x-1, y, sq) + pix(x-1, y+1, sq));
    gy = (pix(x-1, y+1, sq) + 2*pix(x, y+1, sq) + pix(x+1, y+1, sq))
       - (pix(x-1, y-1, sq) + 2*pix(x, y-1, sq) + pix(x+1, y-1, sq));
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 8'hff : 8'(s);
  endfunction

  task automatic chk8(input string tag, input int n, input logic [7:0] got,
                      input logic [7:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_dut(input string name, input int n, input logic in_rst,
                           input int ht, input int hv, input int hsb, input int hse,
                           input int vt, input int vv, input int vsb, input int vse,
                           input int sq, input logic [7:0] d, input logic [5:0] rgb,
                           input logic hs, input logic vs);
    int h, v;
    logic [7:0] ed;
    logic       ehs, evs;
    if (in_rst) begin
      ed = 8'h00; ehs = 1'b1; evs = 1'b1;
    end else begin
      h   = n % ht;
      v   = (n / ht) % vt;
      ed  = (h < hv && v < vv) ? ref_mag(h, v, hv, vv, sq) : 8'h00;
      ehs = !(h >= hsb && h <= hse);
      evs = !(v >= vsb && v <= vse);
    end
    chk8({name, "_data"}, n, d, ed);
    chk8({name, "_rgb"}, n, {2'b00, rgb}, {2'b00, {3{ed[7:6]}}});
    chk8({name, "_hs"}, n, {7'd0, hs}, {7'd0, ehs});
    chk8({name, "_vs"}, n, {7'd0, vs}, {7'd0, evs});
  endtask

  task automatic step();
    logic was_rst;
    @(posedge clk);
    was_rst = rst;
    #1;
    check_dut("big", n_big, was_rst, BH_TOT, BH_VIS, BHS_BEG, BHS_END, BV_TOT, BV_VIS,
              BVS_BEG, BVS_END, BSQ, big_data, big_rgb, big_hs, big_vs);
    check_dut("small", n_sm, was_rst, SH_TOT, SH_VIS, SHS_BEG, SHS_END, SV_TOT, SV_VIS,
              SVS_BEG, SVS_END, SSQ, sm_data, sm_rgb, sm_hs, sm_vs);
    if (!was_rst) begin
      for (int i = 0; i < 10; i++) begin
        if (n_big == dir_n[i]) chk8("dir_data", n_big, big_data, dir_d[i]);
      end
      for (int i = 0; i < 4; i++) begin
        if (n_big == hs_n[i]) chk8("dir_hs", n_big, {7'd0, big_hs}, {7'd0, hs_e[i]});
      end
      if (n_big == 8063) chk8("dir_rgb", n_big, {2'b00, big_rgb}, 8'h3f);
      n_big++;
      n_sm++;
    end else begin
      n_big = 0;
      n_sm  = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (52100) step();
    repeat (3) begin
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      rst = 1'b0;
      repeat ($urandom_range(1760, 2600)) step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/sobel_vga_top.md
Name: sobel_vga_top

Overview:
- Self-contained Sobel edge-detection demo with a VGA 640x480 output.
- An internal pattern generator produces an 8-bit grayscale checkerboard. A 3x3 Sobel operator runs over it using two line buffers.
- The edge magnitude drives an 8-bit data output and a 6-bit RGB (2 bits per colour) VGA port with HS/VS syncs.
- This is the top level of the design; nominal clk is 25 MHz.

Parameters:
- H_VIS, 640: visible pixels per line
- H_TOT, 800: clocks per line
- HS_BEG, 656: first h of HS pulse
- HS_END, 751: last h of HS pulse
- V_VIS, 480: visible lines
- V_TOT, 521: lines per frame
- VS_BEG, 490: first v of VS pulse
- VS_END, 491: last v of VS pulse
- SQ_SHIFT, 6: checkerboard square size is 2^SQ_SHIFT pixels

Ports:
- clk  in  1  system clock; reset rst, synchronous, active-high; clock clk
- rst  in  1  synchronous active-high reset
- out_data  out  8  Sobel magnitude of current pixel; 0 in blanking
- xrgb  out  6  {R[1:0],G[1:0],B[1:0]}
- xhs  out  1  horizontal sync, active low
- xvs  out  1  vertical sync, active low

Behaviour:
- Raster counters:
  - h runs 0..H_TOT-1 and wraps to 0. v increments when h wraps, runs 0..V_TOT-1 and wraps to 0.
  - Frame length is 800*521 = 416800 clocks.
- Reset:
  - While rst=1 at a rising edge: h=v=0, out_data=0, xrgb=0, xhs=1, xvs=1.
  - Line buffers need not be cleared.
  - Reset mid-frame aborts the frame; the next frame restarts at (0,0).
- Output timing:
  - Let E1 be the first rising edge with rst=0. After edge Ek (k>=1), all outputs describe pixel index n=k-1: h=n mod 800, v=(n div 800) mod 521.
  - All outputs are registered (flopped).
- Source image: p(x,y) = 255 if ((x>>SQ_SHIFT) xor (y>>SQ_SHIFT)) bit0 = 1, else 0. Defined for 0<=x<640, 0<=y<480.
- Sobel at visible (x,y):
  - Border pixels (x=0, x=639, y=0, y=479) give M=0.
  - Gx = [p(x+1,y-1)+2p(x+1,y)+p(x+1,y+1)] - [p(x-1,y-1)+2p(x-1,y)+p(x-1,y+1)].
  - Gy = [p(x-1,y+1)+2p(x,y+1)+p(x+1,y+1)] - [p(x-1,y-1)+2p(x,y-1)+p(x+1,y-1)].
  - M = min(255, |Gx|+|Gy|). Use at least 11-bit signed intermediates; no wrap.
- Implementation:
  - The pattern generator/window pipeline runs ahead of the displayed raster (one line plus a few pixels) using two 640x8 line buffers.
  - Only the externally visible result above is required; internal latency is free.
- Output mapping:
  - Visible (h<640 and v<480): out_data=M(h,v) and xrgb={M[7:6],M[7:6],M[7:6]}.
  - Otherwise: out_data=0 and xrgb=0.
- Syncs: xhs=0 iff HS_BEG<=h<=HS_END. xvs=0 iff VS_BEG<=v<=VS_END. Syncs are independent of visibility.
- Frame-to-frame: output is identical every frame; no state carries over except the line buffers, which the pipeline must refill before use.

Test Plan:
- Reset/idle: hold rst=1 for 2 edges -> out_data=00, xrgb=00, xhs=1, xvs=1. Release; after E1 (pixel 0, border) -> out_data=00.
- Square interior: pixel (10,10), n=8010 -> out_data=00, xrgb=00. Pixel (62,10) -> 00.
- Vertical edge: pixels (63,10) and (64,10) -> out_data=FF, xrgb=3F. Pixel (65,10) -> 00.
- Horizontal edge and corner: (10,63), (10,64) and (64,64) -> FF. (10,65) -> 00.
- Sync timing, line 0:
  - xhs=1 at h=655 -> 0 at h=656 -> 0 through h=751 -> 1 at h=752.
  - out_data=00 for all h>=640.
- VS and frame wrap:
  - xvs=0 exactly for lines 490-491 (1600 clocks).
  - Pixel n=416800 is again (0,0).
  - Dump 416801 samples of out_data: samples 0 and 416800 are equal, and the second frame matches the first bit-for-bit.
